trap_sequencer: RTL
===================

Name: trap_sequencer

Overview:
- Initiating side of the ecall trap-handler convention. Detects ecall/mret from the single-cycle core's decoder, saves the trap context, and redirects fetch into the handler code at HANDLER_BASE.
- On mret, returns fetch to the instruction after the trapping one.
- Sits between the decoder and the PC register. The handler image ROM is fetched from the addresses this block emits.

Parameters:
- HANDLER_BASE, 32'h1c090000, trap entry address driven on redirect at trap entry.
- CNT_W, 16, width of the saturating trap counter.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- instr_valid_i  in  1  current instruction is valid and would retire this cycle
- pc_i  in  32  PC of the current instruction
- ecall_i  in  1  decoder flags ecall (qualified by instr_valid_i)
- mret_i  in  1  decoder flags mret (qualified by instr_valid_i)
- illegal_i  in  1  decoder flags illegal instruction (used only with TRAP_ILLEGAL_EN)
- pc_hold_o  out  1  combinational; PC register must not advance this cycle
- redirect_valid_o  out  1  load redirect_pc_o into PC at next edge
- redirect_pc_o  out  32  redirect target
- in_handler_o  out  1  core is executing handler code
- mepc_o  out  32  saved trap PC
- mcause_o  out  4  saved cause code
- halted_o  out  1  double fault; core must stop
- spurious_mret_o  out  1  sticky; mret seen outside handler
- trap_count_o  out  CNT_W  traps taken, saturating

Behaviour:
- FSM states: NORMAL, ENTRY, HANDLER, RETURN, HALT. Reset state is NORMAL.
- Reset values: all outputs 0, mepc 0, mcause 0, counter 0. Reset mid-trap forces NORMAL and clears all context; no redirect is issued.
- A "trap event" is instr_valid_i & ecall_i in cycle N.
- NORMAL, trap event in cycle N:
  - pc_hold_o=1 combinationally in cycle N.
  - At the edge: mepc<=pc_i, mcause<=11, counter +1 (saturating at all-ones), state<=ENTRY.
- ENTRY (exactly 1 cycle): redirect_valid_o=1, redirect_pc_o=HANDLER_BASE, pc_hold_o=0. Next state HANDLER.
- HANDLER: in_handler_o=1.
  - instr_valid_i & mret_i in cycle M: pc_hold_o=1 in M; at the edge state<=RETURN.
- RETURN (exactly 1 cycle): redirect_valid_o=1, redirect_pc_o=mepc+4, computed mod 2^32 so 32'hfffffffc wraps to 0. in_handler_o=1. Next state NORMAL.
- ecall in HANDLER (double fault): pc_hold_o=1; at the edge state<=HALT. mepc, mcause and the counter are unchanged.
- HALT: halted_o=1 and pc_hold_o=1 continuously; all inputs ignored until rst.
- mret in NORMAL: no redirect and no hold (executes as nop); spurious_mret_o set sticky until rst.
- ecall and mret asserted together: ecall has priority.
- All decoder inputs are ignored in ENTRY and RETURN. redirect_valid_o is never high for two consecutive cycles.
- mepc_o and mcause_o are registered and hold their values until the next trap entry.

Optional Feature:
- Macro: TRAP_ILLEGAL_EN.
- Defined:
  - instr_valid_i & illegal_i in NORMAL is a trap event: mcause<=2, mepc<=pc_i, same ENTRY/HANDLER/RETURN flow, return to mepc+4.
  - illegal_i in HANDLER is a double fault (goes to HALT).
  - Priority: ecall > illegal > mret.
- Not defined: illegal_i is ignored entirely; mcause only ever takes the value 11.

Test Plan:
- Reset then ecall at pc_i=32'h00000040 → pc_hold_o=1 that cycle; next cycle redirect_valid_o=1, redirect_pc_o=32'h1c090000; mepc_o=32'h40, mcause_o=11, trap_count_o=1, in_handler_o=1 from the following cycle.
- From HANDLER, mret at pc_i=32'h1c090088 → one cycle later redirect_pc_o=32'h00000044; in_handler_o drops the cycle after; state NORMAL.
- ecall while in HANDLER → halted_o=1 the next cycle and stays high through 10 cycles of further stimulus; mepc_o unchanged; rst clears halted_o.
- mret in NORMAL → no redirect_valid_o, spurious_mret_o=1 and still 1 after a later full trap round-trip.
- ecall at pc_i=32'hfffffffc then mret → return redirect_pc_o=32'h00000000. Separately, 65536 traps → trap_count_o stays 16'hffff.
- Assert rst during ENTRY → redirect_valid_o=0 immediately, all context 0. With TRAP_ILLEGAL_EN: illegal_i at pc_i=32'h100 gives mcause_o=2 and return redirect_pc_o=32'h104; without the macro, the same stimulus produces no hold and no redirect.

Source files
------------

// File: rtl/trap_sequencer_if.sv
// trap_sequencer_if: decoder/PC-side bundle for the ecall/mret trap sequencer
// master: decoder side (drives instruction flags, observes hold/redirect/context)
// slave : trap_sequencer side
interface trap_sequencer_if #(parameter int CNT_W = 16);
  logic             instr_valid_i;
  logic [31:0]      pc_i;
  logic             ecall_i;
  logic             mret_i;
  logic             illegal_i;
  logic             pc_hold_o;
  logic             redirect_valid_o;
  logic [31:0]      redirect_pc_o;
  logic             in_handler_o;
  logic [31:0]      mepc_o;
  logic [3:0]       mcause_o;
  logic             halted_o;
  logic             spurious_mret_o;
  logic [CNT_W-1:0] trap_count_o;
  modport master (
    output instr_valid_i, pc_i, ecall_i, mret_i, illegal_i,
    input  pc_hold_o, redirect_valid_o, redirect_pc_o, in_handler_o,
           mepc_o, mcause_o, halted_o, spurious_mret_o, trap_count_o
  );
  modport slave (
    input  instr_valid_i, pc_i, ecall_i, mret_i, illegal_i,
    output pc_hold_o, redirect_valid_o, redirect_pc_o, in_handler_o,
           mepc_o, mcause_o, halted_o, spurious_mret_o, trap_count_o
  );
endinterface

// File: rtl/trap_sequencer.sv
// trap_sequencer: ecall/mret trap entry/return sequencing with saved context
// Ports: clk, rst (async active-high), bus (trap_sequencer_if.slave):
//   decoder flags in; pc_hold/redirect to the PC register; mepc/mcause,
//   in_handler, halted (double fault), sticky spurious_mret, saturating trap count out.
// Optional: define TRAP_ILLEGAL_EN to make illegal_i a trap source (mcause 2).
module trap_sequencer #(
  parameter logic [31:0] HANDLER_BASE = 32'h1c090000,
  parameter int          CNT_W        = 16
) (
  input logic          clk,
  input logic          rst,
  trap_sequencer_if.slave bus
);
  typedef enum logic [2:0] {NORMAL, ENTRY, HANDLER, RETURN, HALT} state_t;
  state_t           state, state_n;
  logic [31:0]      mepc;
  logic [3:0]       mcause;
  logic [CNT_W-1:0] cnt;
  logic             spur;
  logic             ill;
  logic             trap_ev;
  logic             mret_ev;
  logic             hold;
`ifdef TRAP_ILLEGAL_EN
  assign ill = bus.illegal_i;
`else
  assign ill = 1'b0;
`endif
  assign trap_ev = bus.instr_valid_i & (bus.ecall_i | ill);
  assign mret_ev = bus.instr_valid_i & bus.mret_i;
  always_comb begin
    state_n = state;
    hold    = 1'b0;
    case (state)
      NORMAL: begin
        hold    = trap_ev;
        state_n = trap_ev ? ENTRY : NORMAL;
      end
      ENTRY:  state_n = HANDLER;
      HANDLER: begin
        hold    = trap_ev | mret_ev;
        state_n = trap_ev ? HALT : mret_ev ? RETURN : HANDLER;
      end
      RETURN: state_n = NORMAL;
      HALT: begin
        hold    = 1'b1;
        state_n = HALT;
      end
      default: state_n = NORMAL;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= NORMAL;
      mepc   <= '0;
      mcause <= '0;
      cnt    <= '0;
      spur   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == NORMAL && trap_ev) begin
        mepc   <= bus.pc_i;
        mcause <= bus.ecall_i ? 4'd11 : 4'd2;
        cnt    <= &cnt ? cnt : cnt + CNT_W'(1);
      end
      if (state == NORMAL && mret_ev && !trap_ev)
        spur <= 1'b1;
    end
  end
  assign bus.pc_hold_o        = hold;
  assign bus.redirect_valid_o = state == ENTRY || state == RETURN;
  assign bus.redirect_pc_o    = state == ENTRY ? HANDLER_BASE : state == RETURN ? mepc + 32'd4 : 32'd0;
  assign bus.in_handler_o     = state == HANDLER || state == RETURN;
  assign bus.halted_o         = state == HALT;
  assign bus.mepc_o           = mepc;
  assign bus.mcause_o         = mcause;
  assign bus.spurious_mret_o  = spur;
  assign bus.trap_count_o     = cnt;
endmodule
